// File: rtl/dest_sel_pkg.sv
// Shared constants and the one-hot/priority select helper for dest_sel_pipe.
// The helper works on a fixed maximum width so any N up to SEL_MAX can use it.
package dest_sel_pkg;

    localparam int AW_DEF    = 5;
    localparam int N_DEF     = 3;
    localparam int DEPTH_DEF = 3;

    localparam int SEL_MAX = 32;
    localparam int IDX_W   = $clog2(SEL_MAX);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             multi;
        logic             none;
    } sel_res_t;

    // Lowest set bit wins; multi is set when more than one bit is high.
    function automatic sel_res_t onehot0_lowest(input logic [SEL_MAX-1:0] sel);
        sel_res_t res;
        res = '0;
        for (int k = SEL_MAX - 1; k >= 0; k--) begin
            if (sel[k]) begin
                res.idx = IDX_W'(k);
            end
        end
        res.none  = (sel == '0);
        res.multi = ((sel & (sel - SEL_MAX'(1))) != '0);
        return res;
    endfunction

endpackage

// File: rtl/onehot_prio_mux.sv
// Combinational candidate selector: picks the lowest selected candidate and
// reports whether the select was empty or had more than one bit set.
module onehot_prio_mux
    import dest_sel_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int N  = N_DEF
) (
    input  logic [N*AW-1:0] cand_i,
    input  logic [N-1:0]    sel_i,
    output logic [AW-1:0]   value_o,
    output logic            zero_o,
    output logic            multi_o
);

    sel_res_t res;

    assign res     = onehot0_lowest(SEL_MAX'(sel_i));
    assign zero_o  = res.none;
    assign multi_o = res.multi;

    always_comb begin
        value_o = '0;
        for (int k = 0; k < N; k++) begin
            if (res.idx == IDX_W'(k)) begin
                value_o = cand_i[k*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/dest_sel_pipe.sv
// Write-destination select followed by a DEPTH-stage {valid, address} pipeline
// with every stage tapped and compared against two source-register queries.
module dest_sel_pipe
    import dest_sel_pkg::*;
#(
    parameter int AW            = AW_DEF,
    parameter int N             = N_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter bit ZERO_SUPPRESS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*AW-1:0]    cand_i,
    input  logic [N-1:0]       sel_i,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [2*AW-1:0]    query_i,
    output logic [AW-1:0]      dest_o,
    output logic               valid_o,
    output logic [DEPTH*AW-1:0] tap_dest_o,
    output logic [DEPTH-1:0]   tap_valid_o,
    output logic [2*DEPTH-1:0] hit_o,
    output logic               sel_err_o
);

    logic [AW-1:0] mux_val;
    logic [AW-1:0] hold_q;
    logic [AW-1:0] resolved;
    logic          sel_zero;
    logic          sel_multi;
    logic          stage0_valid;
    logic          accept;

    onehot_prio_mux #(.AW(AW), .N(N)) u_mux (
        .cand_i  (cand_i),
        .sel_i   (sel_i),
        .value_o (mux_val),
        .zero_o  (sel_zero),
        .multi_o (sel_multi)
    );

    // An empty select reuses the last resolved address instead of a candidate.
    assign resolved     = sel_zero ? hold_q : mux_val;
    assign stage0_valid = valid_i && !(ZERO_SUPPRESS && (resolved == '0));

    // Stage 0 captures on every edge with stall_i=0 and flush_i=0; there is no
    // back-pressure to the producer, so a stalled or flushed input is simply
    // not taken and must be presented again.
    assign accept = !stall_i && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            sel_err_o <= 1'b0;
        end else if (accept) begin
            hold_q <= resolved;
            if (valid_i && sel_multi) begin
                sel_err_o <= 1'b1;
            end
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic [AW:0] stage_q;
        logic [AW:0] stage_d;

        if (s == 0) begin : g_head
            assign stage_d = {stage0_valid, resolved};
        end else begin : g_body
            assign stage_d = {tap_valid_o[s-1], tap_dest_o[(s-1)*AW +: AW]};
        end

        // Flush drops only the valid bit; the stale address is harmless.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
            end else if (flush_i) begin
                stage_q[AW] <= 1'b0;
            end else if (!stall_i) begin
                stage_q <= stage_d;
            end
        end

        assign tap_valid_o[s]          = stage_q[AW];
        assign tap_dest_o[s*AW +: AW]  = stage_q[AW-1:0];
    end

    assign dest_o  = tap_dest_o[(DEPTH-1)*AW +: AW];
    assign valid_o = tap_valid_o[DEPTH-1];

    for (genvar q = 0; q < 2; q++) begin : g_query
        logic [AW-1:0] qa;
        assign qa = query_i[q*AW +: AW];
        for (genvar s = 0; s < DEPTH; s++) begin : g_cmp
            assign hit_o[q*DEPTH + s] = tap_valid_o[s]
                                     && (tap_dest_o[s*AW +: AW] == qa)
                                     && !(ZERO_SUPPRESS && (qa == '0));
        end
    end

endmodule
